mem_pipe: RTL and testbench
===========================

MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 Parameter XLEN, 32, data and address width in bits; legal values 32 or 64.
REQ-002 Parameter NB_BYTES, 1024, storage size in bytes; power of two.
REQ-003 Parameter LATENCY, 1, cycles from request accept to response availability; legal range 1..4.
REQ-004 Parameter RSP_DEPTH, 2, response buffer entries; must be at least 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_v  in  1  request valid.
REQ-008 req_ready  out  1  request accepted when req_v && req_ready at the rising edge.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_adr  in  XLEN  byte address; need not be aligned.
REQ-011 req_data  in  XLEN  write data; byte i is bits 8i+7:8i.
REQ-012 req_strb  in  XLEN/8  per-byte write enable.
REQ-013 rsp_v  out  1  response valid.
REQ-014 rsp_ready  in  1  response consumed when rsp_v && rsp_ready.
REQ-015 rsp_data  out  XLEN  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  access out of range.
REQ-017 rsp_we  out  1  echo of req_we for this response.

Function
REQ-018 Every accepted request produces exactly one response, in acceptance order.
REQ-019 Write: for each i with req_strb[i]=1, store byte i of req_data at address req_adr+i at the accept edge; other bytes are unchanged.
REQ-020 Read: rsp_data byte i = memory[req_adr+i], sampled at the accept edge, little-endian.
REQ-021 A read accepted the cycle after a write to the same bytes returns the new data; no hazard stalls are allowed.
REQ-022 Out of range means req_adr + XLEN/8 > NB_BYTES, computed without overflow. It sets rsp_err=1, performs no write, and returns rsp_data=0.
REQ-023 Accepted requests travel a LATENCY-stage valid pipeline, then enter the response FIFO. rsp_v asserts LATENCY cycles after acceptance when the FIFO is empty and rsp_ready=1.
REQ-024 req_ready = (number of requests in the pipeline + FIFO occupancy) < RSP_DEPTH. The response FIFO never overflows, and no response is dropped.
REQ-025 Throughput: with rsp_ready held high and RSP_DEPTH >= LATENCY+1, one request is accepted per cycle.
REQ-026 rsp_v, rsp_data, rsp_err and rsp_we hold stable while rsp_v=1 && rsp_ready=0.
REQ-027 A FIFO push and pop in the same cycle leave occupancy unchanged. A full FIFO with a pop in the same cycle accepts the push.
REQ-028 A write with req_strb=0 changes no memory and still returns a response with rsp_err=0.

Reset
REQ-029 While rst_n=0: pipeline valids and FIFO pointers/count are cleared, rsp_v=0, rsp_data=0, rsp_err=0, rsp_we=0, req_ready=0.
REQ-030 req_ready becomes 1 on the first rising edge after rst_n deasserts.
REQ-031 Memory contents are not reset.
REQ-032 Reset during traffic discards all in-flight requests and responses. Writes already committed at earlier edges persist.

Structure
REQ-033 The shared package mem_pkg holds the response struct (data, err, we) and the legal-range checks for XLEN and LATENCY.
REQ-034 The response buffer is a separate sub-module, mem_rsp_fifo, parametrised by entry type and RSP_DEPTH.
REQ-035 Illegal parameter values stop elaboration with an error.

Verification
REQ-036 Write 0xDEADBEEF, strb 4'b1111, adr 0x10; then read adr 0x10 -> rsp_data 0xDEADBEEF, rsp_err 0, LATENCY cycles after accept.
REQ-037 Write 0x11223344, strb 4'b0101, adr 0x20 over zero memory; then read -> 0x00220044.
REQ-038 Unaligned: write 0xAABBCCDD at adr 0x01; then read adr 0x00 -> 0xBBCCDDxx, where xx = prior byte 0x00.
REQ-039 Out of range, NB_BYTES=1024: read adr 0x3FD -> rsp_err 1, rsp_data 0. Read 0x3FC -> rsp_err 0. Write 0x3FE -> memory unchanged.
REQ-040 Backpressure, LATENCY=2, RSP_DEPTH=3: hold rsp_ready=0 while issuing reads. req_ready drops after 3 accepts. Releasing rsp_ready drains 3 in-order responses, and req_ready recovers.
REQ-041 Assert rst_n=0 with 2 reads in flight -> rsp_v 0 immediately and no stale response after reset. Earlier-written data reads back intact.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and parameter-legality helpers for the mem_pipe slice.
package mem_pkg;

    // Widest supported data path; narrower instances zero-extend into it.
    localparam int XLEN_MAX = 64;

    // One response as it travels through the pipeline and response FIFO.
    typedef struct packed {
        logic [XLEN_MAX-1:0] data;
        logic                err;
        logic                we;
    } mem_rsp_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit latency_legal(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Response buffer: circular FIFO of DEPTH entries of type T.
// Push and pop may coincide, including a push into a full FIFO that is
// being popped in the same cycle.
module mem_rsp_fifo
    import mem_pkg::*;
#(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            pop_ok;
    logic            push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt < CW'(DEPTH)) || pop_ok);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are qualified by the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= din;
    end

    assign dout  = slots[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/mem_pipe.sv
// Byte-addressed memory with a fixed-latency request pipeline feeding an
// in-order response FIFO. The FIFO write is the last pipeline stage, so a
// response is consumable LATENCY edges after its request was accepted.
module mem_pipe
    import mem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NB_BYTES  = 1024,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_v,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_adr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [XLEN/8-1:0] req_strb,
    output logic              rsp_v,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              rsp_we
);

    localparam int NBY = XLEN / 8;
    localparam int AW  = $clog2(NB_BYTES);
    localparam int CW  = $clog2(RSP_DEPTH + 1);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("mem_pipe: XLEN must be 32 or 64");
    end
    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("mem_pipe: LATENCY must be in 1..4");
    end
    if (!is_pow2(NB_BYTES) || (NB_BYTES < NBY)) begin : g_bad_size
        $error("mem_pipe: NB_BYTES must be a power of two holding at least one word");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $error("mem_pipe: RSP_DEPTH must be at least 1");
    end

    logic [7:0]      mem [NB_BYTES];
    logic            run_q;
    logic            acc;
    logic            in_range;
    logic [XLEN:0]   end_adr;
    logic [AW-1:0]   base;
    logic [XLEN-1:0] rd_word;
    mem_rsp_t        rsp_now;
    mem_rsp_t        push_d;
    mem_rsp_t        head;
    logic            push_v;
    logic            pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    int              inflight;
    logic            unused_head_hi;

    // One extra bit keeps the end-address compare free of wraparound.
    assign end_adr  = {1'b0, req_adr} + (XLEN+1)'(NBY);
    assign in_range = (end_adr <= (XLEN+1)'(NB_BYTES));
    assign base     = req_adr[AW-1:0];

    assign req_ready = run_q && ((inflight + int'(fifo_cnt)) < RSP_DEPTH);
    assign acc       = req_v && req_ready;

    // Holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // Little-endian gather of the word starting at the request address.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NBY; i++) begin
            rd_word[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    // Response as seen at the accept edge; writes and errors carry no data.
    always_comb begin
        rsp_now     = '0;
        rsp_now.err = !in_range;
        rsp_now.we  = req_we;
        if (in_range && !req_we) rsp_now.data = XLEN_MAX'(rd_word);
    end

    // Byte-strobed write commit at the accept edge; storage is not reset.
    always_ff @(posedge clk) begin
        if (acc && req_we && in_range) begin
            for (int i = 0; i < NBY; i++) begin
                if (req_strb[i]) mem[base + AW'(i)] <= req_data[8*i +: 8];
            end
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign push_v   = acc;
        assign push_d   = rsp_now;
        assign inflight = 0;
    end else begin : g_stages
        logic [LATENCY-2:0] stg_v;
        mem_rsp_t           stg_d [LATENCY-1];

        // Valid shift chain; cleared by reset so in-flight requests vanish.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_v <= '0;
            end else begin
                stg_v[0] <= acc;
                for (int k = 1; k < LATENCY - 1; k++) stg_v[k] <= stg_v[k-1];
            end
        end

        // Payload shift chain, qualified by stg_v.
        always_ff @(posedge clk) begin
            stg_d[0] <= rsp_now;
            for (int k = 1; k < LATENCY - 1; k++) stg_d[k] <= stg_d[k-1];
        end

        assign push_v   = stg_v[LATENCY-2];
        assign push_d   = stg_d[LATENCY-2];
        assign inflight = $countones(stg_v);
    end

    assign pop = rsp_v && rsp_ready;

    mem_rsp_fifo #(
        .T     (mem_rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_v),
        .din   (push_d),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Outputs are forced to zero whenever no response is presented.
    assign rsp_v          = !fifo_empty;
    assign rsp_data       = rsp_v ? head.data[XLEN-1:0] : '0;
    assign rsp_err        = rsp_v & head.err;
    assign rsp_we         = rsp_v & head.we;
    assign unused_head_hi = ^head.data;

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe with LATENCY=2, RSP_DEPTH=3, 32-bit, 1 KiB.
module tb_mem_pipe;

    localparam int XLEN      = 32;
    localparam int NB_BYTES  = 1024;
    localparam int LATENCY   = 2;
    localparam int RSP_DEPTH = 3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_v     = 1'b0;
    logic        req_ready;
    logic        req_we    = 1'b0;
    logic [31:0] req_adr   = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_strb  = '0;
    logic        rsp_v;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_we;
    logic        stale;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_pipe #(
        .XLEN      (XLEN),
        .NB_BYTES  (NB_BYTES),
        .LATENCY   (LATENCY),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_v     (req_v),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .rsp_v     (rsp_v),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_we    (rsp_we)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] data,
                        input logic [3:0] strb);
        int n = 0;
        req_v    = 1'b1;
        req_we   = we;
        req_adr  = adr;
        req_data = data;
        req_strb = strb;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) chk1("send_timeout", req_ready, 1'b1);
        @(negedge clk);
        req_v    = 1'b0;
        req_we   = 1'b0;
        req_strb = '0;
    endtask

    // Waits (bounded) for a response, checks it, and lets it be consumed.
    task automatic get_rsp(input string tag, input logic [31:0] exp_data,
                           input logic exp_err, input logic exp_we);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_v && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_v"}, rsp_v, 1'b1);
        chk32({tag, "_data"}, rsp_data, exp_data);
        chk1({tag, "_err"}, rsp_err, exp_err);
        chk1({tag, "_we"}, rsp_we, exp_we);
        @(negedge clk);
    endtask

    // Single request with exact-latency check on the response.
    task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [31:0] exp_data, input logic exp_err);
        send(we, adr, data, strb);
        chk1({tag, "_early"}, rsp_v, 1'b0);
        @(negedge clk);
        chk1({tag, "_ontime"}, rsp_v, 1'b1);
        get_rsp(tag, exp_data, exp_err, we);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk1("rst_rsp_v", rsp_v, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk32("rst_rsp_data", rsp_data, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_rsp_we", rsp_we, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("ready_before_edge", req_ready, 1'b0);
        @(negedge clk);
        chk1("ready_after_edge", req_ready, 1'b1);
        rsp_ready = 1'b1;

        // Full-word write and read-back
        txn("wr_dead", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        txn("rd_dead", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Partial strobes over zeroed memory
        txn("wr_zero20", 1'b1, 32'h20, 32'h0, 4'b1111, 32'h0, 1'b0);
        txn("wr_strb", 1'b1, 32'h20, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        txn("rd_strb", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h00220044, 1'b0);

        // Unaligned write straddling two words
        txn("wr_zero00", 1'b1, 32'h00, 32'h0, 4'b1111, 32'h0, 1'b0);
        txn("wr_zero04", 1'b1, 32'h04, 32'h0, 4'b1111, 32'h0, 1'b0);
        txn("wr_unal", 1'b1, 32'h01, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0);
        txn("rd_unal0", 1'b0, 32'h00, 32'h0, 4'b0000, 32'hBBCCDD00, 1'b0);
        txn("rd_unal4", 1'b0, 32'h04, 32'h0, 4'b0000, 32'h000000AA, 1'b0);

        // Read the cycle after a write to the same bytes
        send(1'b1, 32'h40, 32'h12345678, 4'b1111);
        send(1'b0, 32'h40, 32'h0, 4'b0000);
        get_rsp("b2b_wr", 32'h0, 1'b0, 1'b1);
        get_rsp("b2b_rd", 32'h12345678, 1'b0, 1'b0);

        // Range boundary at the top of memory
        txn("wr_top", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        txn("rd_3fd", 1'b0, 32'h3FD, 32'h0, 4'b0000, 32'h0, 1'b1);
        txn("rd_3fc", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
        txn("wr_3fe", 1'b1, 32'h3FE, 32'h55555555, 4'b1111, 32'h0, 1'b1);
        txn("rd_3fc_after", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

        // Write with no strobes
        txn("wr_nostrb", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        txn("rd_nostrb", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Backpressure: three reads fill pipeline plus FIFO
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        send(1'b0, 32'h20, 32'h0, 4'b0000);
        send(1'b0, 32'h00, 32'h0, 4'b0000);
        chk1("bp_full", req_ready, 1'b0);
        chk1("bp_hold_v0", rsp_v, 1'b1);
        chk32("bp_hold_d0", rsp_data, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        chk1("bp_hold_v1", rsp_v, 1'b1);
        chk32("bp_hold_d1", rsp_data, 32'hDEADBEEF);
        chk1("bp_hold_we1", rsp_we, 1'b0);
        chk1("bp_still_full", req_ready, 1'b0);
        get_rsp("bp_r0", 32'hDEADBEEF, 1'b0, 1'b0);
        get_rsp("bp_r1", 32'h00220044, 1'b0, 1'b0);
        get_rsp("bp_r2", 32'hBBCCDD00, 1'b0, 1'b0);
        chk1("bp_recover", req_ready, 1'b1);

        // Reset with two reads in flight
        send(1'b0, 32'h10, 32'h0, 4'b0000);
        send(1'b0, 32'h3FC, 32'h0, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk1("rst_flight_v", rsp_v, 1'b0);
        chk1("rst_flight_ready", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_v) stale = 1'b1;
        end
        chk1("no_stale_rsp", stale, 1'b0);
        txn("post_rst_10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        txn("post_rst_3fc", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
        txn("post_rst_00", 1'b0, 32'h00, 32'h0, 4'b0000, 32'hBBCCDD00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
